// File: rtl/lsu_ctrl.sv
// RV32I load/store sequencer: issues one data-memory access per load/store,
// holds the core in stall until grant/response, error or timeout.
module lsu_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int FUNCTION3 = 3,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 store_i,
  input  logic [FUNCTION3-1:0] fun3_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  output logic                 stall_o,
  output logic                 done_o,
  output logic [DATA_W-1:0]    rdata_o,
  output logic                 misalign_o,
  output logic                 err_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [DATA_W-1:0]    mem_wdata_o,
  output logic [3:0]           mem_wmask_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DATA_W-1:0]    mem_rdata_i
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [FUNCTION3-1:0]   fun3_q, fun3_d;
  logic [1:0]             off_q, off_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [3:0]             mask_q, mask_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  logic stall_c, done_c, misalign_c, err_c, req_c;
  logic access, is_store, legal, misaligned, expired;
  logic [1:0] size;

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lane_wdata(input logic [1:0] sz, input logic [DATA_W-1:0] wd);
    case (sz)
      2'b00:   lane_wdata = {4{wd[7:0]}};
      2'b01:   lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  // fun3[2] selects zero-extension; the low two bits give the access size.
  function automatic logic [DATA_W-1:0] load_extend(input logic [FUNCTION3-1:0] f3,
                                                    input logic [1:0] off,
                                                    input logic [DATA_W-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   load_extend = {{(DATA_W-8){b[7] & ~f3[2]}}, b};
      2'b01:   load_extend = {{(DATA_W-16){h[15] & ~f3[2]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  assign access   = load_i | store_i;
  assign is_store = store_i;
  assign size     = fun3_i[1:0];
  assign legal    = is_store ? (~fun3_i[2] & (size != 2'b11))
                             : ((size != 2'b11) & ~(fun3_i[2] & (size == 2'b10)));
  assign misaligned = ((size == 2'b01) & addr_i[0]) |
                      ((size == 2'b10) & (addr_i[1:0] != 2'b00));
  assign expired  = (cnt_q == CNT_MAX);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    fun3_d     = fun3_q;
    off_d      = off_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    rdata_d    = rdata_q;
    stall_c    = 1'b0;
    done_c     = 1'b0;
    misalign_c = 1'b0;
    err_c      = 1'b0;
    req_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (!legal) begin
            err_c = 1'b1;
          end else if (misaligned) begin
            misalign_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            we_d    = is_store;
            fun3_d  = fun3_i;
            off_d   = addr_i[1:0];
            addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
            wdata_d = lane_wdata(size, wdata_i);
            mask_d  = is_store ? lane_mask(size, addr_i[1:0]) : 4'b0000;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        if (mem_gnt_i) begin
          state_d = we_q ? S_DONE : S_WAIT_R;
        end else if (expired) begin
          req_c   = 1'b0;
          err_c   = 1'b1;
          state_d = S_DONE;
        end
        if (!expired) cnt_d = cnt_q + 1'b1;
      end
      S_WAIT_R: begin
        stall_c = 1'b1;
        if (mem_rvalid_i) begin
          rdata_d = load_extend(fun3_q, off_q, mem_rdata_i);
          state_d = S_DONE;
        end else if (expired) begin
          err_c   = 1'b1;
          state_d = S_DONE;
        end
        if (!expired) cnt_d = cnt_q + 1'b1;
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      fun3_q  <= '0;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= 4'b0000;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      fun3_q  <= fun3_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end

  // Combinational strobes are forced low while reset is held.
  assign stall_o     = stall_c & ~rst;
  assign done_o      = done_c & ~rst;
  assign misalign_o  = misalign_c & ~rst;
  assign err_o       = err_c & ~rst;
  assign mem_req_o   = req_c & ~rst;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wmask_o = mask_q;
  assign rdata_o     = rdata_q;

endmodule
